// File: rtl/axis_burst_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axis_burst_sequencer_pkg
//  Description : Shared definitions for the AXI-Stream burst sequencer.
//                Holds the FSM state encoding and the default widths used
//                by the interface, the FSM and the top level.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package axis_burst_sequencer_pkg;

    // Default widths
    localparam int DEF_TDATA_WIDTH   = 32;
    localparam int DEF_LEN_WIDTH     = 16;
    localparam int DEF_GAP_WIDTH     = 16;
    localparam int DEF_PKT_CNT_WIDTH = 32;

    // Sequencer state encoding
    localparam int         STATE_WIDTH = 2;
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] RUN         = 2'd1;
    localparam logic [1:0] GAP         = 2'd2;

endpackage
`default_nettype wire

// File: rtl/axis_burst_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : axis_burst_sequencer_if
//  Description : AXI-Stream channel bundle (tvalid/tready/tdata/tlast).
//  Modports    : master - drives tvalid, tdata, tlast; receives tready
//                slave  - receives tvalid, tdata, tlast; drives tready
//  Parameters  : DATA_WIDTH - width of tdata
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_burst_sequencer_if
    import axis_burst_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_TDATA_WIDTH
) ();

    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tlast;

    modport master (
        output tvalid,
        output tdata,
        output tlast,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tlast,
        output tready
    );

endinterface
`default_nettype wire

// File: rtl/axis_burst_sequencer_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : axis_burst_sequencer_fsm
//  Description : Control core of the burst sequencer: IDLE/RUN/GAP state,
//                beat counter, gap counter, stop request and the
//                completed-packet counter. Configuration is latched on start
//                and held for the whole sequencing session.
//  Ports       : aclk, aresetn     - clock, synchronous active-low reset
//                cfg_start/stop    - start / stop-at-boundary pulses
//                cfg_continuous    - repeat packets when set
//                cfg_length/gap    - beats per packet / idle cycles between
//                beat              - a beat is transferred this cycle
//                state             - current sequencer state
//                last_beat         - beat counter is at the final beat
//                packet_count      - completed packets (wrapping)
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_burst_sequencer_fsm
    import axis_burst_sequencer_pkg::*;
#(
    parameter int LEN_WIDTH     = DEF_LEN_WIDTH,
    parameter int GAP_WIDTH     = DEF_GAP_WIDTH,
    parameter int PKT_CNT_WIDTH = DEF_PKT_CNT_WIDTH
) (
    input  wire logic                     aclk,
    input  wire logic                     aresetn,
    input  wire logic                     cfg_start,
    input  wire logic                     cfg_stop,
    input  wire logic                     cfg_continuous,
    input  wire logic [LEN_WIDTH-1:0]     cfg_length,
    input  wire logic [GAP_WIDTH-1:0]     cfg_gap,
    input  wire logic                     beat,
    output logic [STATE_WIDTH-1:0]        state,
    output logic                          last_beat,
    output logic [PKT_CNT_WIDTH-1:0]      packet_count
);

    logic [STATE_WIDTH-1:0]   r_state;
    logic [LEN_WIDTH-1:0]     r_beat_cnt;
    logic [GAP_WIDTH-1:0]     r_gap_cnt;
    logic                     r_stop_pending;
    logic [PKT_CNT_WIDTH-1:0] r_packet_count;
    logic [LEN_WIDTH-1:0]     r_length_q;
    logic [GAP_WIDTH-1:0]     r_gap_q;
    logic                     r_continuous_q;

    logic                     w_last_beat;

    // length_q is never zero while running, so length_q - 1 cannot underflow
    // in any state where this compare matters.
    assign w_last_beat = (r_beat_cnt == (r_length_q - LEN_WIDTH'(1)));

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            r_state        <= IDLE;
            r_beat_cnt     <= '0;
            r_gap_cnt      <= '0;
            r_stop_pending <= 1'b0;
            r_packet_count <= '0;
            r_length_q     <= '0;
            r_gap_q        <= '0;
            r_continuous_q <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    // A simultaneous stop cancels the start; zero length is
                    // not a valid packet and is ignored.
                    if (cfg_start && !cfg_stop && (cfg_length != '0)) begin
                        r_state        <= RUN;
                        r_length_q     <= cfg_length;
                        r_gap_q        <= cfg_gap;
                        r_continuous_q <= cfg_continuous;
                        r_beat_cnt     <= '0;
                        r_stop_pending <= 1'b0;
                    end
                end

                RUN: begin
                    // Packets are atomic: a stop is only remembered here and
                    // acted on at the packet boundary below.
                    if (cfg_stop) begin
                        r_stop_pending <= 1'b1;
                    end
                    if (beat) begin
                        if (w_last_beat) begin
                            r_packet_count <= r_packet_count + PKT_CNT_WIDTH'(1);
                            r_beat_cnt     <= '0;
                            if (r_stop_pending || cfg_stop || !r_continuous_q) begin
                                r_state        <= IDLE;
                                r_stop_pending <= 1'b0;
                            end else if (r_gap_q != '0) begin
                                // Count gap_q-1 down to 0 -> gap_q idle cycles
                                r_state   <= GAP;
                                r_gap_cnt <= r_gap_q - GAP_WIDTH'(1);
                            end
                        end else begin
                            r_beat_cnt <= r_beat_cnt + LEN_WIDTH'(1);
                        end
                    end
                end

                GAP: begin
                    if (r_stop_pending || cfg_stop) begin
                        r_state        <= IDLE;
                        r_stop_pending <= 1'b0;
                        r_gap_cnt      <= '0;
                    end else if (r_gap_cnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - GAP_WIDTH'(1);
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign last_beat    = w_last_beat;
    assign packet_count = r_packet_count;

endmodule
`default_nettype wire

// File: rtl/axis_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : axis_burst_sequencer
//  Description : Cuts a free-running AXI-Stream source into fixed-length
//                packets with a configurable idle gap. The source is only
//                allowed to advance while a packet is being emitted; the
//                datapath is a zero-latency combinational pass-through.
//  Ports       : aclk, aresetn     - clock, synchronous active-low reset
//                cfg_start         - pulse: begin sequencing
//                cfg_stop          - pulse: stop at next packet boundary
//                cfg_continuous    - 1 = repeat packets, 0 = single packet
//                cfg_length        - beats per packet
//                cfg_gap           - idle cycles between packets
//                s_axis            - source stream (slave side, tready gated)
//                m_axis            - sink stream (master side, tlast driven)
//                busy              - sequencer not idle
//                packet_count      - number of completed packets
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_burst_sequencer
    import axis_burst_sequencer_pkg::*;
#(
    parameter int AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int LEN_WIDTH        = DEF_LEN_WIDTH,
    parameter int GAP_WIDTH        = DEF_GAP_WIDTH,
    parameter int PKT_CNT_WIDTH    = DEF_PKT_CNT_WIDTH
) (
    input  wire logic                     aclk,
    input  wire logic                     aresetn,
    input  wire logic                     cfg_start,
    input  wire logic                     cfg_stop,
    input  wire logic                     cfg_continuous,
    input  wire logic [LEN_WIDTH-1:0]     cfg_length,
    input  wire logic [GAP_WIDTH-1:0]     cfg_gap,
    axis_burst_sequencer_if.slave         s_axis,
    axis_burst_sequencer_if.master        m_axis,
    output logic                          busy,
    output logic [PKT_CNT_WIDTH-1:0]      packet_count
);

    logic [STATE_WIDTH-1:0] w_state;
    logic                   w_run;
    logic                   w_last_beat;
    logic                   w_m_tvalid;
    logic                   w_beat;
    logic                   unused_s_tlast;

    // The source's own tlast carries no meaning here; packet boundaries are
    // generated locally.
    assign unused_s_tlast = s_axis.tlast;

    axis_burst_sequencer_fsm #(
        .LEN_WIDTH     (LEN_WIDTH),
        .GAP_WIDTH     (GAP_WIDTH),
        .PKT_CNT_WIDTH (PKT_CNT_WIDTH)
    ) u_fsm (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_continuous (cfg_continuous),
        .cfg_length     (cfg_length),
        .cfg_gap        (cfg_gap),
        .beat           (w_beat),
        .state          (w_state),
        .last_beat      (w_last_beat),
        .packet_count   (packet_count)
    );

    assign w_run      = (w_state == RUN);
    assign w_m_tvalid = s_axis.tvalid & w_run;
    assign w_beat     = w_m_tvalid & m_axis.tready;

    // Both directions of the handshake are gated by RUN so neither side can
    // complete a transfer outside a packet.
    assign m_axis.tvalid = w_m_tvalid;
    assign s_axis.tready = m_axis.tready & w_run;
    // Data is zeroed outside RUN so every output is quiet until a start.
    assign m_axis.tdata  = w_run ? s_axis.tdata : '0;
    assign m_axis.tlast  = w_run & w_last_beat;

    assign busy = (w_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axis_burst_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axis_burst_sequencer
//  Description : Self-checking bench for axis_burst_sequencer. A counting
//                source feeds the DUT; a monitor records every transferred
//                beat (data, tlast, cycle). Each scenario task compares the
//                record against packet arithmetic: contiguous data, tlast on
//                every length-th beat, gap+1 cycles between packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axis_burst_sequencer;

    localparam int DW  = 32;
    localparam int LW  = 16;
    localparam int GW  = 16;
    localparam int PW  = 32;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          cfg_start = 1'b0;
    logic          cfg_stop = 1'b0;
    logic          cfg_continuous = 1'b0;
    logic [LW-1:0] cfg_length = '0;
    logic [GW-1:0] cfg_gap = '0;
    logic          busy;
    logic [PW-1:0] packet_count;

    logic          src_valid = 1'b0;
    logic [DW-1:0] src_data = '0;
    logic          sink_ready = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int model_pkts = 0;

    logic [DW-1:0] q_data[$];
    bit            q_last[$];
    int            q_cyc[$];

    axis_burst_sequencer_if #(.DATA_WIDTH(DW)) s_if ();
    axis_burst_sequencer_if #(.DATA_WIDTH(DW)) m_if ();

    assign s_if.tvalid = src_valid;
    assign s_if.tdata  = src_data;
    assign s_if.tlast  = 1'b0;
    assign m_if.tready = sink_ready;

    axis_burst_sequencer #(
        .AXIS_TDATA_WIDTH (DW),
        .LEN_WIDTH        (LW),
        .GAP_WIDTH        (GW),
        .PKT_CNT_WIDTH    (PW)
    ) dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .cfg_start      (cfg_start),
        .cfg_stop       (cfg_stop),
        .cfg_continuous (cfg_continuous),
        .cfg_length     (cfg_length),
        .cfg_gap        (cfg_gap),
        .s_axis         (s_if),
        .m_axis         (m_if),
        .busy           (busy),
        .packet_count   (packet_count)
    );

    always #5 aclk = ~aclk;

    always @(posedge aclk) cyc <= cyc + 1;

    // Free-running counter source: advances only on an accepted handshake.
    always @(posedge aclk) begin
        if (!aresetn)
            src_data <= '0;
        else if (s_if.tvalid && s_if.tready)
            src_data <= src_data + 1;
    end

    // Beat monitor, sampled mid-cycle.
    always @(negedge aclk) begin
        if (m_if.tvalid && m_if.tready) begin
            q_data.push_back(m_if.tdata);
            q_last.push_back(m_if.tlast);
            q_cyc.push_back(cyc);
        end
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_last.delete();
        q_cyc.delete();
    endtask

    task automatic pulse_start(input int len, input int gap, input bit cont);
        cfg_length     = LW'(len);
        cfg_gap        = GW'(gap);
        cfg_continuous = cont;
        cfg_start      = 1'b1;
        tick();
        cfg_start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output bit ok, output int fall_cyc);
        ok = 1'b0;
        fall_cyc = -1;
        for (int n = 0; n < budget; n++) begin
            if (!busy) begin
                ok = 1'b1;
                fall_cyc = cyc;
                return;
            end
            tick();
        end
    endtask

    task automatic wait_beats(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            if (q_data.size() >= target) begin
                ok = 1'b1;
                return;
            end
            tick();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        aresetn    = 1'b0;
        src_valid  = 1'b1;
        sink_ready = 1'b1;
        cfg_start  = 1'b1;
        cfg_length = 16'd4;
        repeat (3) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b want 0", m_if.tvalid); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b want 0", m_if.tlast); end
        checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL reset_s_tready: got %b want 0", s_if.tready); end
        checks++; if (packet_count !== '0) begin errors++; $display("FAIL reset_pkt_cnt: got %0d want 0", packet_count); end
        checks++; if (m_if.tdata !== '0) begin errors++; $display("FAIL reset_tdata: got %0h want 0", m_if.tdata); end
        cfg_start = 1'b0;
        aresetn   = 1'b1;
        repeat (2) tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b want 0", busy); end
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL post_reset_tvalid: got %b want 0", m_if.tvalid); end
        checks++; if (src_data !== '0) begin errors++; $display("FAIL post_reset_src_held: got %0d want 0", src_data); end
        model_pkts = 0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_shot();
        int base, fall;
        bit ok;
        clear_q();
        src_valid  = 1'b1;
        sink_ready = 1'b1;
        base = int'(src_data);
        pulse_start(4, 0, 1'b0);
        wait_idle(100, ok, fall);
        checks++; if (!ok) begin errors++; $display("FAIL single_timeout: busy stuck at %b, want 0", busy); end
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL single_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== DW'(base + i)) begin errors++; $display("FAIL single_data[%0d]: got %0d want %0d", i, q_data[i], base + i); end
            checks++; if (q_last[i] !== (i == 3)) begin errors++; $display("FAIL single_tlast[%0d]: got %b want %b", i, q_last[i], (i == 3)); end
        end
        if (q_cyc.size() == 4) begin
            checks++; if (fall != q_cyc[3] + 1) begin errors++; $display("FAIL single_busy_fall: got cycle %0d want %0d", fall, q_cyc[3] + 1); end
        end
        model_pkts += 1;
        checks++; if (packet_count !== PW'(model_pkts)) begin errors++; $display("FAIL single_pkt_cnt: got %0d want %0d", packet_count, model_pkts); end
        repeat (3) tick();
        checks++; if (src_data !== DW'(base + 4)) begin errors++; $display("FAIL single_src_held: got %0d want %0d", src_data, base + 4); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_continuous(input int len, input int gap, input int npkts);
        int base, fall, exp_p, exp_beats, n, want_diff;
        bit ok;
        clear_q();
        src_valid  = 1'b1;
        sink_ready = 1'b1;
        base = int'(src_data);
        pulse_start(len, gap, 1'b1);
        // New configuration while busy must be ignored.
        cfg_length     = LW'($urandom_range(1, 9));
        cfg_gap        = GW'($urandom_range(0, 9));
        cfg_continuous = 1'b0;
        n = 0;
        while (packet_count !== PW'(model_pkts + npkts) && n < 1000) begin
            tick();
            n++;
        end
        checks++; if (n >= 1000) begin errors++; $display("FAIL cont_timeout: pkt_cnt %0d want %0d", packet_count, model_pkts + npkts); end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_idle(200, ok, fall);
        checks++; if (!ok) begin errors++; $display("FAIL cont_stop_timeout: busy %b want 0", busy); end
        // Stop lands in GAP when gap>0; with gap==0 the next packet is
        // already under way and must complete.
        exp_p     = (gap == 0) ? npkts + 1 : npkts;
        exp_beats = exp_p * len;
        checks++; if (q_data.size() != exp_beats) begin errors++; $display("FAIL cont_beats(L%0d G%0d): got %0d want %0d", len, gap, q_data.size(), exp_beats); end
        for (int i = 0; i < exp_beats && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== DW'(base + i)) begin errors++; $display("FAIL cont_data[%0d]: got %0d want %0d", i, q_data[i], base + i); end
            checks++; if (q_last[i] !== ((i % len) == len - 1)) begin errors++; $display("FAIL cont_tlast[%0d]: got %b want %b", i, q_last[i], ((i % len) == len - 1)); end
            if (i > 0) begin
                want_diff = ((i % len) == 0) ? gap + 1 : 1;
                checks++; if (q_cyc[i] - q_cyc[i-1] != want_diff) begin errors++; $display("FAIL cont_spacing[%0d](L%0d G%0d): got %0d want %0d", i, len, gap, q_cyc[i] - q_cyc[i-1], want_diff); end
            end
        end
        model_pkts += exp_p;
        checks++; if (packet_count !== PW'(model_pkts)) begin errors++; $display("FAIL cont_pkt_cnt: got %0d want %0d", packet_count, model_pkts); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_stall();
        int base, fall, n;
        bit ok;
        clear_q();
        src_valid  = 1'b1;
        sink_ready = 1'b1;
        base = int'(src_data);
        pulse_start(4, 0, 1'b0);
        wait_beats(2, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stall_pre_timeout: beats %0d want 2", q_data.size()); end
        sink_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 2) begin
                // Start while busy must not restart or resize the packet.
                cfg_length = 16'd7;
                cfg_start  = 1'b1;
            end else begin
                cfg_start  = 1'b0;
            end
            tick();
            checks++; if (q_data.size() != 2) begin errors++; $display("FAIL stall_beats[%0d]: got %0d want 2", k, q_data.size()); end
            checks++; if (s_if.tready !== 1'b0) begin errors++; $display("FAIL stall_s_tready[%0d]: got %b want 0", k, s_if.tready); end
        end
        cfg_start = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            sink_ready = 1'($urandom_range(0, 1));
            src_valid  = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checks++; if (n >= 300) begin errors++; $display("FAIL stall_timeout: busy %b want 0", busy); end
        src_valid  = 1'b1;
        sink_ready = 1'b1;
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL stall_total_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== DW'(base + i)) begin errors++; $display("FAIL stall_data[%0d]: got %0d want %0d", i, q_data[i], base + i); end
            checks++; if (q_last[i] !== (i == 3)) begin errors++; $display("FAIL stall_tlast[%0d]: got %b want %b", i, q_last[i], (i == 3)); end
        end
        model_pkts += 1;
        checks++; if (packet_count !== PW'(model_pkts)) begin errors++; $display("FAIL stall_pkt_cnt: got %0d want %0d", packet_count, model_pkts); end
        wait_idle(5, ok, fall);
    endtask

    // ------------------------------------------------------------------
    task automatic test_stop();
        int base, fall, n;
        bit ok;
        src_valid  = 1'b1;
        sink_ready = 1'b1;

        // Stop during beat 1: packet completes, no GAP follows.
        clear_q();
        base = int'(src_data);
        pulse_start(4, 3, 1'b1);
        wait_beats(1, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL stopA_timeout: beats %0d want 1", q_data.size()); end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        wait_idle(100, ok, fall);
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL stopA_beats: got %0d want 4", q_data.size()); end
        for (int i = 0; i < 4 && i < q_data.size(); i++) begin
            checks++; if (q_data[i] !== DW'(base + i)) begin errors++; $display("FAIL stopA_data[%0d]: got %0d want %0d", i, q_data[i], base + i); end
            checks++; if (q_last[i] !== (i == 3)) begin errors++; $display("FAIL stopA_tlast[%0d]: got %b want %b", i, q_last[i], (i == 3)); end
        end
        if (q_cyc.size() == 4) begin
            checks++; if (fall != q_cyc[3] + 1) begin errors++; $display("FAIL stopA_busy_fall: got cycle %0d want %0d", fall, q_cyc[3] + 1); end
        end
        repeat (8) tick();
        checks++; if (q_data.size() != 4) begin errors++; $display("FAIL stopA_no_more: got %0d want 4", q_data.size()); end
        model_pkts += 1;

        // Zero-length start is ignored; stop in IDLE leaves nothing behind.
        pulse_start(0, 0, 1'b1);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL len0_busy: got %b want 0", busy); end
        repeat (3) tick();
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL len0_tvalid: got %b want 0", m_if.tvalid); end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        clear_q();
        pulse_start(2, 0, 1'b0);
        wait_idle(50, ok, fall);
        checks++; if (q_data.size() != 2) begin errors++; $display("FAIL idle_stop_then_start: got %0d beats want 2", q_data.size()); end
        model_pkts += 1;

        // Stop coincident with the last beat: IDLE right after it.
        clear_q();
        pulse_start(3, 0, 1'b1);
        n = 0;
        while (!m_if.tlast && n < 20) begin
            tick();
            n++;
        end
        checks++; if (n >= 20) begin errors++; $display("FAIL stopC_timeout: tlast %b want 1", m_if.tlast); end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stopC_busy: got %b want 0", busy); end
        checks++; if (q_data.size() != 3) begin errors++; $display("FAIL stopC_beats: got %0d want 3", q_data.size()); end
        model_pkts += 1;

        // Stop while in GAP.
        clear_q();
        pulse_start(2, 5, 1'b1);
        n = 0;
        while (packet_count !== PW'(model_pkts + 1) && n < 50) begin
            tick();
            n++;
        end
        checks++; if (n >= 50) begin errors++; $display("FAIL stopD_timeout: pkt_cnt %0d want %0d", packet_count, model_pkts + 1); end
        repeat (2) tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL stopD_in_gap_busy: got %b want 1", busy); end
        cfg_stop = 1'b1;
        tick();
        cfg_stop = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stopD_busy: got %b want 0", busy); end
        repeat (8) tick();
        checks++; if (q_data.size() != 2) begin errors++; $display("FAIL stopD_beats: got %0d want 2", q_data.size()); end
        model_pkts += 1;
        checks++; if (packet_count !== PW'(model_pkts)) begin errors++; $display("FAIL stop_pkt_cnt: got %0d want %0d", packet_count, model_pkts); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid();
        bit ok;
        bit saw_last;
        int nb;
        clear_q();
        src_valid  = 1'b1;
        sink_ready = 1'b1;
        pulse_start(6, 0, 1'b0);
        wait_beats(2, 50, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: beats %0d want 2", q_data.size()); end
        aresetn = 1'b0;
        tick();
        checks++; if (m_if.tvalid !== 1'b0) begin errors++; $display("FAIL rstmid_tvalid: got %b want 0", m_if.tvalid); end
        checks++; if (m_if.tlast !== 1'b0) begin errors++; $display("FAIL rstmid_tlast: got %b want 0", m_if.tlast); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
        checks++; if (packet_count !== '0) begin errors++; $display("FAIL rstmid_pkt_cnt: got %0d want 0", packet_count); end
        saw_last = 1'b0;
        foreach (q_last[i]) saw_last |= q_last[i];
        checks++; if (saw_last !== 1'b0) begin errors++; $display("FAIL rstmid_no_tlast: got %b want 0", saw_last); end
        aresetn = 1'b1;
        model_pkts = 0;
        tick();

        // Start and stop together in IDLE: stop wins.
        clear_q();
        cfg_length = 16'd4;
        cfg_start  = 1'b1;
        cfg_stop   = 1'b1;
        tick();
        cfg_start  = 1'b0;
        cfg_stop   = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: got %b want 0", busy); end
        repeat (4) tick();
        nb = q_data.size();
        checks++; if (nb != 0) begin errors++; $display("FAIL start_stop_beats: got %0d want 0", nb); end
    endtask

    initial begin
        int len, gap, np;
        test_reset();
        test_single_shot();
        test_continuous(3, 2, 2);
        test_continuous(2, 0, 3);
        for (int r = 0; r < 5; r++) begin
            len = $urandom_range(1, 5);
            gap = $urandom_range(0, 4);
            np  = $urandom_range(1, 3);
            test_continuous(len, gap, np);
        end
        test_stall();
        test_stall();
        test_stop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
